// File: rtl/multivoice_oscillator_pkg.sv
// Shared types for the multivoice oscillator: waveform encodings, FSM states,
// and the fixed-point sine kernel used to build the sine ROM at elaboration.
package multivoice_oscillator_pkg;

   typedef enum logic [1:0] {
      WAVE_SAW    = 2'd0,
      WAVE_SQUARE = 2'd1,
      WAVE_TRI    = 2'd2,
      WAVE_SINE   = 2'd3
   } wave_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // pi/2 in Q30
   localparam longint HALF_PI_Q30 = 64'sd1686629713;

   // Taylor series of sin(x) for x in [0, pi/2], x and result in Q30.
   function automatic longint sine_q30(input longint x);
      longint term;
      longint sum;
      term = x;
      sum  = x;
      for (int n = 1; n <= 8; n++) begin
         term = (term * x) >>> 30;
         term = (term * x) >>> 30;
         term = -term / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return sum;
   endfunction

endpackage

// File: rtl/multivoice_oscillator_if.sv
// Sample request, per-voice configuration and mixed sample output bundle.
interface multivoice_oscillator_if
   import multivoice_oscillator_pkg::*;
#(
   parameter int BITSIZE   = 16,
   parameter int PHASESIZE = 16,
   parameter int VOICES    = 4
) ();
   localparam int VW = $clog2(VOICES);

   logic                        sample_tick;
   logic                        cfg_we;
   logic [VW-1:0]               cfg_voice;
   logic [PHASESIZE-1:0]        cfg_freq;
   wave_t                       cfg_wave;
   logic                        cfg_enable;
   logic signed [BITSIZE-1:0]   out;
   logic                        out_valid;
   logic                        busy;
   logic                        overrun;

   modport master (
      output sample_tick, cfg_we, cfg_voice, cfg_freq, cfg_wave, cfg_enable,
      input  out, out_valid, busy, overrun
   );

   modport slave (
      input  sample_tick, cfg_we, cfg_voice, cfg_freq, cfg_wave, cfg_enable,
      output out, out_valid, busy, overrun
   );
endinterface

// File: rtl/sine_rom.sv
// Full-period sine table with a registered read; contents are computed at
// elaboration from quarter-wave symmetry so the peaks and zeros are exact.
module sine_rom
   import multivoice_oscillator_pkg::*;
#(
   parameter int BITSIZE   = 16,
   parameter int TABLESIZE = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [TABLESIZE-1:0]       addr,
   output logic signed [BITSIZE-1:0]  data
);
   localparam int     DEPTH   = 1 << TABLESIZE;
   localparam int     QUARTER = DEPTH / 4;
   localparam longint AMP     = (longint'(1) <<< (BITSIZE - 1)) - 1;

   function automatic logic signed [BITSIZE-1:0] table_entry(input int i);
      int     quad;
      int     j;
      longint x;
      longint mag;
      quad = i / QUARTER;
      j    = i % QUARTER;
      if (quad == 1 || quad == 3) j = QUARTER - j;
      x   = longint'(j) * HALF_PI_Q30 / longint'(QUARTER);
      mag = (sine_q30(x) * AMP + (longint'(1) <<< 29)) >>> 30;
      if (mag > AMP) mag = AMP;
      if (mag < 0)   mag = 0;
      if (quad >= 2) mag = -mag;
      return BITSIZE'(mag);
   endfunction

   logic signed [BITSIZE-1:0] table_q [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      localparam logic signed [BITSIZE-1:0] ENTRY = table_entry(i);
      assign table_q[i] = ENTRY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data <= '0;
      else        data <= table_q[addr];
   end
endmodule

// File: rtl/multivoice_oscillator.sv
// Time-multiplexed oscillator: one voice per cycle is evaluated, accumulated
// and mixed into a single signed sample per sample_tick.
//
// state   | meaning
// IDLE    | waiting for sample_tick (busy may still be high on the out_valid cycle)
// RUN     | visiting voice idx, one voice per cycle
// DONE    | folding in the last voice and registering the mixed sample
module multivoice_oscillator
   import multivoice_oscillator_pkg::*;
#(
   parameter int BITSIZE   = 16,
   parameter int PHASESIZE = 16,
   parameter int VOICES    = 4,
   parameter int TABLESIZE = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   multivoice_oscillator_if.slave  bus
);
   localparam int VW   = $clog2(VOICES);
   localparam int ACCW = BITSIZE + VW;

   state_t                     state;
   state_t                     state_nx;
   logic [VW-1:0]              idx;
   logic                       last_voice;
   logic                       busy;
   logic                       tick_ok;

   logic [PHASESIZE-1:0]       freq  [VOICES];
   logic [PHASESIZE-1:0]       phase [VOICES];
   wave_t                      wave  [VOICES];
   logic [VOICES-1:0]          enable;

   logic [PHASESIZE-1:0]       cur_phase;
   logic [BITSIZE-1:0]         ph_top;
   logic [PHASESIZE-2:0]       folded;
   logic [PHASESIZE-1:0]       ramp;
   logic signed [BITSIZE-1:0]  wave_val;
   logic signed [BITSIZE-1:0]  rom_data;

   logic                       stg_valid;
   logic                       stg_en;
   logic                       stg_sine;
   logic signed [BITSIZE-1:0]  stg_val;
   logic signed [BITSIZE-1:0]  contrib;
   logic signed [ACCW-1:0]     acc;
   logic signed [ACCW-1:0]     acc_sum;

   logic signed [BITSIZE-1:0]  out_q;
   logic                       out_valid_q;
   logic                       overrun_q;

   assign busy       = (state != ST_IDLE) || out_valid_q;
   assign tick_ok    = bus.sample_tick && !busy;
   assign last_voice = (idx == VW'(VOICES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (tick_ok) state_nx = ST_RUN;
         ST_RUN:  if (last_voice) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // idx wraps to zero after the last voice because VOICES is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                idx <= '0;
      else if (state == ST_RUN)  idx <= idx + 1'b1;
      else                       idx <= '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < VOICES; v++) begin
            freq[v] <= '0;
            wave[v] <= WAVE_SAW;
         end
         enable <= '0;
      end else if (bus.cfg_we) begin
         freq[bus.cfg_voice]   <= bus.cfg_freq;
         wave[bus.cfg_voice]   <= bus.cfg_wave;
         enable[bus.cfg_voice] <= bus.cfg_enable;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < VOICES; v++) phase[v] <= '0;
      end else begin
         for (int v = 0; v < VOICES; v++) begin
            if (!enable[v])
               phase[v] <= '0;
            else if (state == ST_RUN && idx == VW'(v))
               phase[v] <= phase[v] + freq[v];
         end
      end
   end

   always_comb begin
      cur_phase = phase[idx];
      ph_top    = cur_phase[PHASESIZE-1 -: BITSIZE];
      folded    = cur_phase[PHASESIZE-1] ? ~cur_phase[PHASESIZE-2:0] : cur_phase[PHASESIZE-2:0];
      ramp      = {folded, 1'b0};
      wave_val  = '0;
      case (wave[idx])
         WAVE_SAW:    wave_val = {~ph_top[BITSIZE-1], ph_top[BITSIZE-2:0]};
         WAVE_SQUARE: wave_val = cur_phase[PHASESIZE-1] ? {1'b1, {(BITSIZE-1){1'b0}}}
                                                        : {1'b0, {(BITSIZE-1){1'b1}}};
         WAVE_TRI:    wave_val = {~ramp[PHASESIZE-1], ramp[PHASESIZE-2 -: BITSIZE-1]};
         default:     wave_val = '0;
      endcase
   end

   sine_rom #(
      .BITSIZE   (BITSIZE),
      .TABLESIZE (TABLESIZE)
   ) u_sine_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (cur_phase[PHASESIZE-1 -: TABLESIZE]),
      .data  (rom_data)
   );

   // Stage aligns the computed waveforms with the ROM's one-cycle read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_valid <= 1'b0;
         stg_en    <= 1'b0;
         stg_sine  <= 1'b0;
         stg_val   <= '0;
      end else begin
         stg_valid <= (state == ST_RUN);
         stg_en    <= enable[idx];
         stg_sine  <= (wave[idx] == WAVE_SINE);
         stg_val   <= wave_val;
      end
   end

   assign contrib = stg_en ? (stg_sine ? rom_data : stg_val) : '0;
   assign acc_sum = acc + {{VW{contrib[BITSIZE-1]}}, contrib};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              acc <= '0;
      else if (tick_ok)                        acc <= '0;
      else if (state == ST_RUN && stg_valid)   acc <= acc_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         out_valid_q <= (state == ST_DONE);
         if (state == ST_DONE) out_q <= acc_sum[ACCW-1:VW];
         if (bus.sample_tick && busy) overrun_q <= 1'b1;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_multivoice_oscillator.sv
// Self-checking bench for multivoice_oscillator: a behavioural voice model
// feeds a scoreboard of expected samples that a monitor pops on out_valid.
module tb_multivoice_oscillator;
   import multivoice_oscillator_pkg::*;

   localparam int B = 16;
   localparam int P = 16;
   localparam int V = 4;
   localparam int T = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multivoice_oscillator_if #(.BITSIZE(B), .PHASESIZE(P), .VOICES(V)) bus ();

   multivoice_oscillator #(.BITSIZE(B), .PHASESIZE(P), .VOICES(V), .TABLESIZE(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks    = 0;
   int errors    = 0;
   int valid_cnt = 0;
   logic signed [B-1:0] sb [$];
   logic signed [B-1:0] mon_exp;

   int m_freq  [V];
   int m_wave  [V];
   int m_phase [V];
   bit m_en    [V];

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         valid_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sample_unexpected: out_valid with out=%0d, required no sample", bus.out);
         end else begin
            mon_exp = sb.pop_front();
            if (bus.out !== mon_exp) begin
               errors++;
               $display("FAIL sample: out=%0d required %0d", bus.out, mon_exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int model_wave(input int ph, input int w);
      real r;
      int  i;
      case (w)
         0: return ph - 32768;
         1: return (ph < 32768) ? 32767 : -32768;
         2: return ((ph < 32768) ? 2 * ph : 2 * (65535 - ph)) - 32768;
         default: begin
            i = ph >> 6;
            r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 1024.0);
            if (r >= 0.0) return $rtoi(r + 0.5);
            else          return -$rtoi(-r + 0.5);
         end
      endcase
   endfunction

   function automatic logic signed [B-1:0] model_sample();
      int sum;
      sum = 0;
      for (int v = 0; v < V; v++) begin
         if (m_en[v]) begin
            sum += model_wave(m_phase[v], m_wave[v]);
            m_phase[v] = (m_phase[v] + m_freq[v]) & 32'hFFFF;
         end
      end
      sum = sum >>> 2;
      return B'(sum);
   endfunction

   task automatic model_reset();
      for (int v = 0; v < V; v++) begin
         m_freq[v] = 0; m_wave[v] = 0; m_phase[v] = 0; m_en[v] = 1'b0;
      end
   endtask

   task automatic drive_idle();
      bus.sample_tick = 1'b0;
      bus.cfg_we      = 1'b0;
      bus.cfg_voice   = '0;
      bus.cfg_freq    = '0;
      bus.cfg_wave    = WAVE_SAW;
      bus.cfg_enable  = 1'b0;
   endtask

   task automatic cfg_write(input int v, input int f, input int w, input bit e);
      @(posedge clk); #1;
      bus.cfg_we     = 1'b1;
      bus.cfg_voice  = 2'(v);
      bus.cfg_freq   = 16'(f);
      bus.cfg_wave   = wave_t'(2'(w));
      bus.cfg_enable = e;
      @(posedge clk); #1;
      bus.cfg_we     = 1'b0;
      m_freq[v] = f & 32'hFFFF;
      m_wave[v] = w;
      m_en[v]   = e;
      if (!e) m_phase[v] = 0;
   endtask

   task automatic clear_voices();
      for (int v = 0; v < V; v++) cfg_write(v, 0, 0, 1'b0);
   endtask

   // Leaves the bench one cycle after the tick cycle (voice 0 RUN slot).
   task automatic start_tick();
      sb.push_back(model_sample());
      bus.sample_tick = 1'b1;
      @(posedge clk); #1;
      bus.sample_tick = 1'b0;
   endtask

   task automatic finish_tick();
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL tick_timeout: no out_valid within %0d cycles, required within 6", n);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_tick();
      start_tick();
      finish_tick();
   endtask

   task automatic test_reset();
      drive_idle();
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out !== 16'sd0)     begin errors++; $display("FAIL reset_out: got %0d required 0", bus.out); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
      checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      checks++; if (bus.overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b required 0", bus.overrun); end
   endtask

   task automatic test_saw();
      int exp_c [3] = '{-8192, -7168, -6144};
      cfg_write(0, 'h1000, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send_tick();
         checks++;
         if (bus.out !== exp_c[i]) begin errors++; $display("FAIL saw[%0d]: got %0d required %0d", i, bus.out, exp_c[i]); end
      end
   endtask

   task automatic test_square();
      int exp_c [2] = '{32767, -32768};
      clear_voices();
      for (int v = 0; v < V; v++) cfg_write(v, 'h8000, 1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         send_tick();
         checks++;
         if (bus.out !== exp_c[i]) begin errors++; $display("FAIL square[%0d]: got %0d required %0d", i, bus.out, exp_c[i]); end
      end
   endtask

   task automatic test_sine();
      int exp_c [4] = '{0, 8191, 0, -8192};
      clear_voices();
      cfg_write(0, 'h4000, 3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send_tick();
         checks++;
         if (bus.out !== exp_c[i]) begin errors++; $display("FAIL sine[%0d]: got %0d required %0d", i, bus.out, exp_c[i]); end
      end
   endtask

   // Four identical saw voices make out equal to a single voice's saw exactly.
   task automatic test_wrap();
      int exp_c [3] = '{-32768, 32767, 32766};
      clear_voices();
      for (int v = 0; v < V; v++) cfg_write(v, 'hFFFF, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send_tick();
         checks++;
         if (bus.out !== exp_c[i]) begin errors++; $display("FAIL wrap[%0d]: got %0d required %0d", i, bus.out, exp_c[i]); end
      end
   endtask

   task automatic test_back_to_back();
      clear_voices();
      cfg_write(0, 'h0C40, 0, 1'b1);
      cfg_write(1, 'h2345, 1, 1'b1);
      cfg_write(2, 'h1111, 2, 1'b1);
      cfg_write(3, 'h0D00, 3, 1'b1);
      for (int i = 0; i < 8; i++) send_tick();
      checks++;
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL back_to_back_overrun: got %b required 0", bus.overrun); end
   endtask

   task automatic test_timing();
      int lat;
      clear_voices();
      cfg_write(0, 'h1000, 0, 1'b1);
      sb.push_back(model_sample());
      bus.sample_tick = 1'b1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_tick_cycle: got %b required 0", bus.busy); end
      @(posedge clk); #1;
      bus.sample_tick = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_after_tick: got %b required 1", bus.busy); end
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat != 6) begin errors++; $display("FAIL latency: got %0d cycles required 6", lat); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_valid_cycle: got %b required 1", bus.busy); end
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL after_valid: busy=%b out_valid=%b required 0 0", bus.busy, bus.out_valid);
      end
   endtask

   // A write on voice 0 during its own RUN slot must only affect the next sample.
   task automatic test_cfg_slot();
      int exp_c [3] = '{-8192, -7168, -4096};
      clear_voices();
      cfg_write(0, 'h1000, 0, 1'b1);
      start_tick();
      bus.cfg_we     = 1'b1;
      bus.cfg_voice  = 2'd0;
      bus.cfg_freq   = 16'h3000;
      bus.cfg_wave   = WAVE_SAW;
      bus.cfg_enable = 1'b1;
      m_freq[0] = 'h3000;
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
      finish_tick();
      checks++; if (bus.out !== exp_c[0]) begin errors++; $display("FAIL cfg_slot[0]: got %0d required %0d", bus.out, exp_c[0]); end
      for (int i = 1; i < 3; i++) begin
         send_tick();
         checks++;
         if (bus.out !== exp_c[i]) begin errors++; $display("FAIL cfg_slot[%0d]: got %0d required %0d", i, bus.out, exp_c[i]); end
      end
   endtask

   task automatic test_overrun();
      int cyc;
      int v0;
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b required 0", bus.overrun); end
      clear_voices();
      cfg_write(0, 'h1000, 0, 1'b1);
      v0 = valid_cnt;
      sb.push_back(model_sample());
      bus.sample_tick = 1'b1;
      @(posedge clk); #1; bus.sample_tick = 1'b0; cyc = 1;
      @(posedge clk); #1; bus.sample_tick = 1'b1; cyc = 2;
      @(posedge clk); #1; bus.sample_tick = 1'b0; cyc = 3;
      while (!bus.out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (cyc != 6) begin errors++; $display("FAIL overrun_latency: got %0d cycles required 6", cyc); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL overrun_valid_count: got %0d required 1", valid_cnt - v0); end
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b required 1", bus.overrun); end
      send_tick();
      checks++; if (bus.out !== -16'sd7168) begin errors++; $display("FAIL overrun_no_advance: got %0d required -7168", bus.out); end
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_held: got %b required 1", bus.overrun); end
   endtask

   task automatic test_reset_mid_run();
      int v0;
      start_tick();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrun_busy: got %b required 0", bus.busy); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrun_out_valid: got %b required 0", bus.out_valid); end
      sb.delete();
      model_reset();
      v0 = valid_cnt;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (valid_cnt != v0)       begin errors++; $display("FAIL midrun_no_valid: got %0d pulses required 0", valid_cnt - v0); end
      checks++; if (bus.overrun !== 1'b0)  begin errors++; $display("FAIL midrun_overrun: got %b required 0", bus.overrun); end
      checks++; if (bus.out !== 16'sd0)    begin errors++; $display("FAIL midrun_out: got %0d required 0", bus.out); end
      cfg_write(0, 'h1000, 0, 1'b1);
      send_tick();
      checks++; if (bus.out !== -16'sd8192) begin errors++; $display("FAIL midrun_restart: got %0d required -8192", bus.out); end
   endtask

   initial begin
      test_reset();
      test_saw();
      test_square();
      test_sine();
      test_wrap();
      test_back_to_back();
      test_timing();
      test_cfg_slot();
      test_overrun();
      test_reset_mid_run();
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d samples outstanding, required 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
